// File: rtl/alu_exception_unit.sv
// ALU exception unit: traps on retiring ALU ops, latches EPC/cause/badvaddr,
// then pulses flush and holds the request until it is acked.
module alu_exception_unit #(
  parameter int         CNT_W        = 16,
  parameter logic [4:0] DEFAULT_MASK = 5'b11111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [3:0]       alu_control,
  input  logic [7:0]       alu_status,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      pc,
  input  logic             mask_we,
  input  logic [4:0]       mask_wdata,
  input  logic             exc_ack,
  output logic             flush,
  output logic             exc_req,
  output logic [31:0]      epc,
  output logic [4:0]       cause,
  output logic [31:0]      badvaddr,
  output logic             lost,
  output logic [CNT_W-1:0] cnt_adel,
  output logic [CNT_W-1:0] cnt_ades,
  output logic [CNT_W-1:0] cnt_ovf,
  output logic [CNT_W-1:0] cnt_mulovf,
  output logic [CNT_W-1:0] cnt_div0
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam logic [4:0] C_ADEL = 5'd4;
  localparam logic [4:0] C_ADES = 5'd5;
  localparam logic [4:0] C_OVF  = 5'd12;
  localparam logic [4:0] C_MUL  = 5'd13;
  localparam logic [4:0] C_DIV0 = 5'd15;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [4:0]       r_mask;
  logic             r_flush;
  logic             r_exc_req;
  logic [31:0]      r_epc;
  logic [4:0]       r_cause;
  logic [31:0]      r_badvaddr;
  logic             r_lost;
  logic [CNT_W-1:0] r_cnt_adel;
  logic [CNT_W-1:0] r_cnt_ades;
  logic [CNT_W-1:0] r_cnt_ovf;
  logic [CNT_W-1:0] r_cnt_mul;
  logic [CNT_W-1:0] r_cnt_div0;

  // Detected conditions, bit order {div0, mul_ovf, addsub_ovf, ades, adel}
  logic [4:0]  w_det;
  logic [4:0]  w_trap_vec;
  logic        w_trap;
  logic [4:0]  w_cause;
  logic [31:0] w_badv;
  logic [4:0]  w_cnt_sel;

  assign w_det[0] = alu_valid && (alu_control == 4'd12) && !alu_status[3];
  assign w_det[1] = alu_valid && (alu_control == 4'd13) && !alu_status[3];
  assign w_det[2] = alu_valid
                 && ((alu_control == 4'd2) || (alu_control == 4'd6))
                 && (alu_status[5] != alu_result[31]);
  assign w_det[3] = alu_valid && (alu_control == 4'd5) && alu_status[6];
  assign w_det[4] = alu_valid && (alu_control == 4'd4) && alu_status[2];

  assign w_trap_vec = w_det & r_mask;
  assign w_trap     = |w_trap_vec;

  // Pick the highest-priority enabled trap: div0 > adel > ades > mul > ovf
  always_comb begin
    w_cause = 5'd0;
    w_badv  = 32'd0;
    if (w_trap_vec[4]) begin
      w_cause = C_DIV0;
    end else if (w_trap_vec[0]) begin
      w_cause = C_ADEL;
      w_badv  = alu_result;
    end else if (w_trap_vec[1]) begin
      w_cause = C_ADES;
      w_badv  = alu_result;
    end else if (w_trap_vec[3]) begin
      w_cause = C_MUL;
    end else if (w_trap_vec[2]) begin
      w_cause = C_OVF;
    end
  end

  // One-hot counter select with the same priority, mask not applied
  always_comb begin
    w_cnt_sel = 5'd0;
    if (w_det[4])      w_cnt_sel[4] = 1'b1;
    else if (w_det[0]) w_cnt_sel[0] = 1'b1;
    else if (w_det[1]) w_cnt_sel[1] = 1'b1;
    else if (w_det[3]) w_cnt_sel[3] = 1'b1;
    else if (w_det[2]) w_cnt_sel[2] = 1'b1;
  end

  // Trap-enable mask; a write lands after the current cycle's decision
  always_ff @(posedge clk) begin
    if (reset)        r_mask <= DEFAULT_MASK;
    else if (mask_we) r_mask <= mask_wdata;
  end

  // Exception FSM with registered outputs and capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_flush    <= 1'b0;
      r_exc_req  <= 1'b0;
      r_epc      <= 32'd0;
      r_cause    <= 5'd0;
      r_badvaddr <= 32'd0;
      r_lost     <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_trap) begin
            r_state    <= FLUSH;
            r_flush    <= 1'b1;
            r_exc_req  <= 1'b1;
            r_epc      <= pc;
            r_cause    <= w_cause;
            r_badvaddr <= w_badv;
          end
        end
        FLUSH: begin
          r_state <= PENDING;
          if (w_trap) r_lost <= 1'b1;
        end
        PENDING: begin
          if (exc_ack) begin
            if (w_trap) begin
              r_state    <= FLUSH;
              r_flush    <= 1'b1;
              r_epc      <= pc;
              r_cause    <= w_cause;
              r_badvaddr <= w_badv;
            end else begin
              r_state   <= IDLE;
              r_exc_req <= 1'b0;
            end
          end else if (w_trap) begin
            r_lost <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_exc_req <= 1'b0;
        end
      endcase
    end
  end

  // Saturating per-cause event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_adel <= '0;
      r_cnt_ades <= '0;
      r_cnt_ovf  <= '0;
      r_cnt_mul  <= '0;
      r_cnt_div0 <= '0;
    end else begin
      if (w_cnt_sel[0] && r_cnt_adel != CNT_MAX)
        r_cnt_adel <= r_cnt_adel + 1'b1;
      if (w_cnt_sel[1] && r_cnt_ades != CNT_MAX)
        r_cnt_ades <= r_cnt_ades + 1'b1;
      if (w_cnt_sel[2] && r_cnt_ovf != CNT_MAX)
        r_cnt_ovf <= r_cnt_ovf + 1'b1;
      if (w_cnt_sel[3] && r_cnt_mul != CNT_MAX)
        r_cnt_mul <= r_cnt_mul + 1'b1;
      if (w_cnt_sel[4] && r_cnt_div0 != CNT_MAX)
        r_cnt_div0 <= r_cnt_div0 + 1'b1;
    end
  end

  assign flush      = r_flush;
  assign exc_req    = r_exc_req;
  assign epc        = r_epc;
  assign cause      = r_cause;
  assign badvaddr   = r_badvaddr;
  assign lost       = r_lost;
  assign cnt_adel   = r_cnt_adel;
  assign cnt_ades   = r_cnt_ades;
  assign cnt_ovf    = r_cnt_ovf;
  assign cnt_mulovf = r_cnt_mul;
  assign cnt_div0   = r_cnt_div0;

endmodule

// File: tb/tb_alu_exception_unit.sv
// Directed bench for alu_exception_unit (2-bit counters to reach saturation).
module tb_alu_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_control;
  logic [7:0]  alu_status;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        mask_we;
  logic [4:0]  mask_wdata;
  logic        exc_ack;
  logic        flush;
  logic        exc_req;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic [31:0] badvaddr;
  logic        lost;
  logic [1:0]  cnt_adel;
  logic [1:0]  cnt_ades;
  logic [1:0]  cnt_ovf;
  logic [1:0]  cnt_mulovf;
  logic [1:0]  cnt_div0;

  int tests  = 0;
  int failed = 0;

  alu_exception_unit #(.CNT_W(2), .DEFAULT_MASK(5'b11111)) dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid),
    .alu_control(alu_control), .alu_status(alu_status),
    .alu_result(alu_result), .pc(pc), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .exc_ack(exc_ack), .flush(flush),
    .exc_req(exc_req), .epc(epc), .cause(cause),
    .badvaddr(badvaddr), .lost(lost), .cnt_adel(cnt_adel),
    .cnt_ades(cnt_ades), .cnt_ovf(cnt_ovf),
    .cnt_mulovf(cnt_mulovf), .cnt_div0(cnt_div0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [3:0] c, input logic [7:0] s,
                    input logic [31:0] r, input logic [31:0] p);
    alu_valid   = 1'b1;
    alu_control = c;
    alu_status  = s;
    alu_result  = r;
    pc          = p;
  endtask

  task automatic ack_out();
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_control = 4'd0;
    alu_status = 8'd0; alu_result = 32'd0; pc = 32'd0;
    mask_we = 1'b0; mask_wdata = 5'd0; exc_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_req", {31'd0, exc_req}, 0);
    chk("rst_lost", {31'd0, lost}, 0);
    chk("rst_epc", epc, 0);
    chk("rst_cause", {27'd0, cause}, 0);
    chk("rst_badv", badvaddr, 0);
    chk("rst_cdiv", {30'd0, cnt_div0}, 0);

    // div0 capture
    op(4'd4, 8'h84, 32'd0, 32'h0040_0010);
    tick();
    alu_valid = 1'b0;
    chk("div_flush", {31'd0, flush}, 1);
    chk("div_req", {31'd0, exc_req}, 1);
    chk("div_cause", {27'd0, cause}, 15);
    chk("div_epc", epc, 32'h0040_0010);
    chk("div_badv", badvaddr, 0);
    chk("div_cnt", {30'd0, cnt_div0}, 1);
    tick();
    chk("div_flush2", {31'd0, flush}, 0);
    chk("div_req2", {31'd0, exc_req}, 1);
    ack_out();
    chk("div_acked", {31'd0, exc_req}, 0);

    // misaligned load; ack in FLUSH cycle is ignored
    op(4'd12, 8'h00, 32'h1000_0006, 32'h0040_0020);
    tick();
    alu_valid = 1'b0;
    chk("adel_cause", {27'd0, cause}, 4);
    chk("adel_badv", badvaddr, 32'h1000_0006);
    chk("adel_cnt", {30'd0, cnt_adel}, 1);
    exc_ack = 1'b1;
    tick();
    chk("ack_in_flush", {31'd0, exc_req}, 1);
    chk("adel_flush0", {31'd0, flush}, 0);
    tick();
    exc_ack = 1'b0;
    chk("adel_acked", {31'd0, exc_req}, 0);

    // misaligned store
    op(4'd13, 8'h00, 32'h1000_0006, 32'h0040_0030);
    tick();
    alu_valid = 1'b0;
    chk("ades_cause", {27'd0, cause}, 5);
    chk("ades_cnt", {30'd0, cnt_ades}, 1);
    tick();
    ack_out();
    chk("ades_acked", {31'd0, exc_req}, 0);

    // aligned access: no trap
    op(4'd12, 8'h08, 32'h1000_0008, 32'h0040_0034);
    tick();
    alu_valid = 1'b0;
    chk("align_flush", {31'd0, flush}, 0);
    chk("align_req", {31'd0, exc_req}, 0);
    chk("align_cnt", {30'd0, cnt_adel}, 1);

    // add overflow
    op(4'd2, 8'h00, 32'h8000_0000, 32'h0040_0040);
    tick();
    alu_valid = 1'b0;
    chk("ovf_cause", {27'd0, cause}, 12);
    chk("ovf_epc", epc, 32'h0040_0040);
    chk("ovf_cnt", {30'd0, cnt_ovf}, 1);
    tick();
    ack_out();

    // masked overflow still counts
    mask_we = 1'b1; mask_wdata = 5'b11011;
    tick();
    mask_we = 1'b0;
    op(4'd2, 8'h00, 32'h8000_0000, 32'h0040_0044);
    tick();
    alu_valid = 1'b0;
    chk("mask_req", {31'd0, exc_req}, 0);
    chk("mask_cnt", {30'd0, cnt_ovf}, 2);

    // mask write with a trap in the same cycle uses old mask
    mask_we = 1'b1; mask_wdata = 5'b11111;
    op(4'd6, 8'h20, 32'h0000_0001, 32'h0040_0048);
    tick();
    mask_we = 1'b0; alu_valid = 1'b0;
    chk("oldmask_req", {31'd0, exc_req}, 0);
    chk("oldmask_cnt", {30'd0, cnt_ovf}, 3);

    // mul overflow, then div0 while pending
    op(4'd5, 8'h40, 32'h0000_1234, 32'h0040_0050);
    tick();
    alu_valid = 1'b0;
    chk("mul_cause", {27'd0, cause}, 13);
    chk("mul_cnt", {30'd0, cnt_mulovf}, 1);
    tick();
    op(4'd4, 8'h04, 32'd0, 32'h0040_0060);
    tick();
    alu_valid = 1'b0;
    chk("lost_set", {31'd0, lost}, 1);
    chk("lost_cause", {27'd0, cause}, 13);
    chk("lost_epc", epc, 32'h0040_0050);
    chk("lost_cnt", {30'd0, cnt_div0}, 2);
    chk("lost_req", {31'd0, exc_req}, 1);

    // back-to-back: trap in the ack cycle
    exc_ack = 1'b1;
    op(4'd13, 8'h00, 32'h2000_0003, 32'h0040_0070);
    tick();
    exc_ack = 1'b0; alu_valid = 1'b0;
    chk("b2b_req", {31'd0, exc_req}, 1);
    chk("b2b_flush", {31'd0, flush}, 1);
    chk("b2b_cause", {27'd0, cause}, 5);
    chk("b2b_epc", epc, 32'h0040_0070);
    chk("b2b_badv", badvaddr, 32'h2000_0003);
    chk("b2b_cnt", {30'd0, cnt_ades}, 2);
    tick();
    chk("b2b_flush0", {31'd0, flush}, 0);
    ack_out();
    chk("b2b_acked", {31'd0, exc_req}, 0);

    // saturation: five div0 events
    op(4'd4, 8'h04, 32'd0, 32'h0040_0080);
    for (int i = 0; i < 5; i++) tick();
    alu_valid = 1'b0;
    chk("sat_cnt", {30'd0, cnt_div0}, 3);
    chk("sat_cause", {27'd0, cause}, 15);
    chk("sat_req", {31'd0, exc_req}, 1);

    // clear mask while pending, then reset mid-exception
    mask_we = 1'b1; mask_wdata = 5'b00000;
    tick();
    mask_we = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_req", {31'd0, exc_req}, 0);
    chk("mrst_flush", {31'd0, flush}, 0);
    chk("mrst_lost", {31'd0, lost}, 0);
    chk("mrst_epc", epc, 0);
    chk("mrst_cause", {27'd0, cause}, 0);
    chk("mrst_badv", badvaddr, 0);
    chk("mrst_cnts",
        {22'd0, cnt_adel, cnt_ades, cnt_ovf, cnt_mulovf, cnt_div0}, 0);

    // default mask restored: overflow traps again
    op(4'd2, 8'h00, 32'h8000_0000, 32'h0040_0090);
    tick();
    alu_valid = 1'b0;
    chk("dmask_req", {31'd0, exc_req}, 1);
    chk("dmask_cause", {27'd0, cause}, 12);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
